stream_sched: RTL and testbench
===============================

Name: stream_sched

Overview:
- Top-level phase sequencer for one HPU stream batch: load, then compute, then drain, repeated for N jobs.
- Drives `run` (the active-low reset of the src/dst stream controllers) and `stream_ok` (the dst-controller start condition). Issues the core start pulse and watches the dst AXI-stream handshake for end-of-job.
- Adds a per-phase watchdog so a hung phase cannot stall the host.

Parameters:
- JOB_W, 8: width of the job count and job index.
- TIMEOUT, 4096: max cycles allowed in one waiting phase before fault.
- TO_W, $clog2(TIMEOUT+1): watchdog counter width (derived, not overridden).

Ports:
- clk  in  1  clock.
- rst  in  1  synchronous, active-high reset.
- start  in  1  host start pulse; sampled only in IDLE or FAULT.
- n_jobs  in  JOB_W  job count; latched on accepted start.
- load_done  in  1  single-cycle pulse from the source loader: vectors loaded.
- core_fin  in  1  single-cycle pulse from the cores: compute finished.
- dst_valid  in  1  dst stream valid (from the dst controller).
- dst_last  in  1  dst stream last.
- dst_ready  in  1  downstream ready.
- run  out  1  high while a job is active; low resets the sub-controllers.
- load_req  out  1  level, high in LOAD.
- core_start  out  1  single-cycle pulse on entry to EXEC.
- stream_ok  out  1  level, high in ARM.
- busy  out  1  high in any state except IDLE and FAULT.
- done  out  1  single-cycle pulse when the batch completes.
- fault  out  1  sticky watchdog fault.
- job_idx  out  JOB_W  index of the current job, 0-based.

Behaviour:
- Reset values: state IDLE. All outputs 0, job_idx 0, watchdog 0.
- Outputs are registered or decoded from state only; there is no combinational path from inputs to outputs.
- States:
  - IDLE:
    - start with n_jobs==0 → done pulse next cycle, stay IDLE.
    - start with n_jobs>0 → latch n_jobs, set job_idx=0, go LOAD.
  - LOAD: run=1, load_req=1. On load_done → EXEC.
  - EXEC: run=1. core_start is high for the first cycle of EXEC only. On core_fin → ARM. A core_fin in the same cycle as core_start is valid.
  - ARM: run=1, stream_ok=1. Hold until dst_valid & dst_ready is seen, then go DRAIN. stream_ok is held because the dst controller samples it only while dst_ready=1.
  - DRAIN: run=1. On dst_valid & dst_ready & dst_last → GAP.
    - If the handshake is already complete in ARM (1-beat stream), go ARM → GAP directly.
  - GAP: exactly one cycle with run=0, to clear the sub-controller state. Then:
    - if job_idx == latched count−1 → DONE;
    - else job_idx+1 → LOAD.
  - DONE: one cycle, done=1, run=0 → IDLE. job_idx holds its last value until the next accepted start.
  - FAULT: fault=1, run=0, busy=0. Exit only via rst, or start (which clears fault and behaves as from IDLE).
- Watchdog:
  - Cleared on every state transition.
  - Increments each cycle in LOAD, EXEC and ARM.
  - Increments in DRAIN only when dst_ready=1; backpressure is not a fault.
  - On reaching TIMEOUT with no exit event that cycle → FAULT. An exit event in the same cycle wins.
- Simultaneous events:
  - Stray load_done, core_fin or dst_last in a state that does not expect them are ignored.
  - start while busy is ignored.
- rst mid-operation: immediate return to IDLE with all outputs cleared; no done pulse.
- Arithmetic:
  - job_idx increment is unsigned JOB_W and cannot wrap, because the terminal compare precedes the increment.
  - The latched count is unchanged by n_jobs changes after start.

Decomposition:
- Shared package `hpu_pkg`:
  - state enum `sched_state_t` (IDLE, LOAD, EXEC, ARM, DRAIN, GAP, DONE, FAULT);
  - default TIMEOUT constant.
- Sub-module `sched_wdog`: a loadable clear/enable counter with a terminal-count flag. It is reusable by the other stream controllers.
- The FSM stays inline.

Test Plan:
- n_jobs=2, load_done 3 cycles after LOAD, core_fin 5 cycles after core_start, 4-beat dst stream with dst_ready=1:
  - two LOAD/EXEC/ARM/DRAIN passes;
  - run low exactly 1 cycle between jobs;
  - job_idx 0 then 1;
  - one done pulse; busy falls with done.
- n_jobs=0 start → done=1 on next cycle; run, load_req and busy stay 0.
- dst_ready low for 6000 cycles mid-DRAIN (TIMEOUT=4096) → no fault. Resuming completes the job normally.
- load_done never arrives → fault=1 exactly TIMEOUT cycles after LOAD entry, with run=0. A following start clears fault and runs the batch.
- Single-beat stream (dst_valid, dst_last and dst_ready all high in the first ARM cycle) → ARM→GAP with no DRAIN cycle.
- rst asserted during EXEC of job 1 of 3 → all outputs 0 the next cycle, no done. start and core_fin asserted while busy are ignored.

Source files
------------

// File: rtl/hpu_pkg.sv
// Shared types and defaults for the HPU stream controllers.
package hpu_pkg;

  // Default watchdog budget, in cycles, for one waiting phase.
  localparam int SCHED_TIMEOUT = 4096;

  // Phases of one stream batch; IDLE is the all-zero encoding so reset lands there.
  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    LOAD  = 3'd1,
    EXEC  = 3'd2,
    ARM   = 3'd3,
    DRAIN = 3'd4,
    GAP   = 3'd5,
    DONE  = 3'd6,
    FAULT = 3'd7
  } sched_state_t;

endpackage

// File: rtl/sched_wdog.sv
// Clear/load/enable cycle counter with a terminal-count flag.
// tc is high in the cycle whose increment would reach LIMIT, so the owner can
// react at that same edge. tc depends only on en and the stored count, which
// keeps it free of any loop through the owner's clear logic.
module sched_wdog
  import hpu_pkg::*;
#(
  parameter int LIMIT = SCHED_TIMEOUT,
  parameter int W     = $clog2(LIMIT + 1)
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         clr,
  input  logic         en,
  input  logic         ld,
  input  logic [W-1:0] ld_val,
  output logic         tc
);

  localparam logic [W-1:0] LAST_CNT = W'(LIMIT - 1);
  localparam logic [W-1:0] MAX_CNT  = W'(LIMIT);

  logic [W-1:0] cnt_d, cnt_q;

  // Next count: clear wins over load, load wins over increment; saturates at LIMIT.
  always_comb begin
    cnt_d = cnt_q;
    if (clr) begin
      cnt_d = '0;
    end else if (ld) begin
      cnt_d = ld_val;
    end else if (en && (cnt_q < MAX_CNT)) begin
      cnt_d = cnt_q + 1'b1;
    end
  end

  // Count register with synchronous reset.
  always_ff @(posedge clk) begin
    if (rst) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign tc = en && (cnt_q >= LAST_CNT);

endmodule

// File: rtl/stream_sched.sv
// Phase sequencer for one HPU stream batch: LOAD -> EXEC -> ARM/DRAIN -> GAP,
// repeated per job, with a watchdog that parks the block in FAULT if any
// waiting phase stalls. Every output is a state decode or a flop.
module stream_sched
  import hpu_pkg::*;
#(
  parameter  int JOB_W   = 8,
  parameter  int TIMEOUT = SCHED_TIMEOUT,
  localparam int TO_W    = $clog2(TIMEOUT + 1)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [JOB_W-1:0] n_jobs,
  input  logic             load_done,
  input  logic             core_fin,
  input  logic             dst_valid,
  input  logic             dst_last,
  input  logic             dst_ready,
  output logic             run,
  output logic             load_req,
  output logic             core_start,
  output logic             stream_ok,
  output logic             busy,
  output logic             done,
  output logic             fault,
  output logic [JOB_W-1:0] job_idx
);

  sched_state_t     state_d, state_q;
  logic [JOB_W-1:0] count_d, count_q;
  logic [JOB_W-1:0] idx_d, idx_q;
  logic             done_d, done_q;
  logic             cs_d, cs_q;
  logic             wd_en, wd_clr, wd_tc;
  logic             beat;

  assign beat = dst_valid && dst_ready;

  sched_wdog #(
    .LIMIT (TIMEOUT),
    .W     (TO_W)
  ) u_wdog (
    .clk    (clk),
    .rst    (rst),
    .clr    (wd_clr),
    .en     (wd_en),
    .ld     (1'b0),
    .ld_val ('0),
    .tc     (wd_tc)
  );

  // Next-state, job bookkeeping and watchdog control; exit events beat the timeout.
  always_comb begin
    state_d = state_q;
    count_d = count_q;
    idx_d   = idx_q;
    done_d  = 1'b0;
    wd_en   = 1'b0;
    case (state_q)
      IDLE, FAULT: begin
        if (start) begin
          if (n_jobs == '0) begin
            done_d  = 1'b1;
            state_d = IDLE;
          end else begin
            count_d = n_jobs;
            idx_d   = '0;
            state_d = LOAD;
          end
        end
      end
      LOAD: begin
        wd_en = 1'b1;
        if (load_done)  state_d = EXEC;
        else if (wd_tc) state_d = FAULT;
      end
      EXEC: begin
        wd_en = 1'b1;
        if (core_fin)   state_d = ARM;
        else if (wd_tc) state_d = FAULT;
      end
      ARM: begin
        wd_en = 1'b1;
        if (beat)       state_d = dst_last ? GAP : DRAIN;
        else if (wd_tc) state_d = FAULT;
      end
      DRAIN: begin
        wd_en = dst_ready;
        if (beat && dst_last) state_d = GAP;
        else if (wd_tc)       state_d = FAULT;
      end
      GAP: begin
        if (idx_q == count_q - 1'b1) begin
          state_d = DONE;
        end else begin
          idx_d   = idx_q + 1'b1;
          state_d = LOAD;
        end
      end
      DONE: begin
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase
    if (state_d == DONE) done_d = 1'b1;
    cs_d   = (state_d == EXEC) && (state_q != EXEC);
    wd_clr = (state_d != state_q);
  end

  // State and registered-output flops with synchronous reset.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      count_q <= '0;
      idx_q   <= '0;
      done_q  <= 1'b0;
      cs_q    <= 1'b0;
    end else begin
      state_q <= state_d;
      count_q <= count_d;
      idx_q   <= idx_d;
      done_q  <= done_d;
      cs_q    <= cs_d;
    end
  end

  assign run        = (state_q == LOAD) || (state_q == EXEC) ||
                      (state_q == ARM)  || (state_q == DRAIN);
  assign load_req   = (state_q == LOAD);
  assign stream_ok  = (state_q == ARM);
  assign busy       = (state_q != IDLE) && (state_q != FAULT);
  assign fault      = (state_q == FAULT);
  assign core_start = cs_q;
  assign done       = done_q;
  assign job_idx    = idx_q;

endmodule

// File: tb/tb_stream_sched.sv
// Self-checking bench for stream_sched. Each batch is expanded up front into a
// per-cycle script (stimulus plus expected outputs) built from the phase rules:
// LOAD lasts until load_done, EXEC until core_fin, ARM until the first beat,
// DRAIN until the last beat, then one GAP cycle; DONE after the final job.
module tb_stream_sched;

  localparam int JOB_W   = 8;
  localparam int TIMEOUT = 4096;

  logic             clk = 1'b0;
  logic             rst;
  logic             start;
  logic [JOB_W-1:0] n_jobs;
  logic             load_done;
  logic             core_fin;
  logic             dst_valid;
  logic             dst_last;
  logic             dst_ready;
  logic             run;
  logic             load_req;
  logic             core_start;
  logic             stream_ok;
  logic             busy;
  logic             done;
  logic             fault;
  logic [JOB_W-1:0] job_idx;

  int total = 0;
  int bad   = 0;

  typedef struct {
    string       tag;
    bit          chk;
    bit          rst;
    bit          start;
    logic [7:0]  n;
    bit          ld;
    bit          cf;
    bit          v;
    bit          l;
    bit          r;
    logic [14:0] exp;
  } step_t;

  step_t      q[$];
  logic [7:0] lastIdx;

  stream_sched #(
    .JOB_W   (JOB_W),
    .TIMEOUT (TIMEOUT)
  ) dut (
    .clk        (clk),
    .rst        (rst),
    .start      (start),
    .n_jobs     (n_jobs),
    .load_done  (load_done),
    .core_fin   (core_fin),
    .dst_valid  (dst_valid),
    .dst_last   (dst_last),
    .dst_ready  (dst_ready),
    .run        (run),
    .load_req   (load_req),
    .core_start (core_start),
    .stream_ok  (stream_ok),
    .busy       (busy),
    .done       (done),
    .fault      (fault),
    .job_idx    (job_idx)
  );

  always #5 clk = ~clk;

  function automatic bit coin();
    return ($urandom_range(0, 3) == 0);
  endfunction

  // Expected outputs packed as {run,load_req,core_start,stream_ok,busy,done,fault,job_idx}.
  function automatic step_t mk(string tag, bit eRun, bit eLd, bit eCs, bit eSok,
                               bit eBusy, bit eDone, bit eFault, logic [7:0] eIdx);
    step_t s;
    s.tag   = tag;
    s.chk   = 1'b1;
    s.rst   = 1'b0;
    s.start = 1'b0;
    s.n     = 8'($urandom_range(0, 255));
    s.ld    = 1'b0;
    s.cf    = 1'b0;
    s.v     = 1'b0;
    s.l     = 1'b0;
    s.r     = 1'b0;
    s.exp   = {eRun, eLd, eCs, eSok, eBusy, eDone, eFault, eIdx};
    return s;
  endfunction

  task automatic checkOutput(input string tag, input logic [14:0] obs, input logic [14:0] exp);
    total++;
    if (obs !== exp) begin
      bad++;
      $display("[TB] FAIL %s at %0t: got %h expected %h", tag, $time, obs, exp);
    end
  endtask

  task automatic applyStimulus(input step_t s);
    rst       = s.rst;
    start     = s.start;
    n_jobs    = s.n;
    load_done = s.ld;
    core_fin  = s.cf;
    dst_valid = s.v;
    dst_last  = s.l;
    dst_ready = s.r;
  endtask

  task automatic pushIdle(input string tag, input int cycles);
    for (int i = 0; i < cycles; i++) q.push_back(mk(tag, 0, 0, 0, 0, 0, 0, 0, lastIdx));
  endtask

  // Start cycle seen from IDLE (or FAULT); a zero count yields only a done pulse.
  task automatic pushStart(input int nj, input bit fromFault);
    step_t s;
    s = mk("start", 0, 0, 0, 0, 0, 0, fromFault, lastIdx);
    s.start = 1'b1;
    s.n     = 8'(nj);
    q.push_back(s);
    if (nj == 0) begin
      q.push_back(mk("zero done", 0, 0, 0, 0, 0, 1, 0, lastIdx));
    end
  endtask

  task automatic pushDone(input int nj);
    step_t s;
    s = mk("done", 0, 0, 0, 0, 1, 1, 0, 8'(nj - 1));
    s.start = coin(); s.ld = coin(); s.cf = coin(); s.v = coin(); s.l = coin(); s.r = coin();
    q.push_back(s);
    lastIdx = 8'(nj - 1);
    pushIdle("after done", 1);
  endtask

  // One job: L idle LOAD cycles before load_done, E before core_fin, B beats,
  // optional long backpressure before the last beat; clean mode has no waits or strays.
  task automatic genJob(input int j, input int L, input int E, input int B,
                        input int stall, input bit clean);
    step_t s;
    int    w;
    for (int k = 0; k <= L; k++) begin
      s = mk("load", 1, 1, 0, 0, 1, 0, 0, 8'(j));
      if (k == L) s.ld = 1'b1;
      else if (!clean) begin
        s.cf = coin(); s.l = coin(); s.v = coin(); s.r = coin(); s.start = coin();
      end
      q.push_back(s);
    end
    for (int k = 0; k <= E; k++) begin
      s = mk("exec", 1, 0, (k == 0), 0, 1, 0, 0, 8'(j));
      if (k == E) s.cf = 1'b1;
      else if (!clean) begin
        s.ld = coin(); s.l = coin(); s.v = coin(); s.r = coin(); s.start = coin();
      end
      q.push_back(s);
    end
    w = clean ? 0 : $urandom_range(0, 3);
    for (int k = 0; k < w; k++) begin
      s = mk("arm wait", 1, 0, 0, 1, 1, 0, 0, 8'(j));
      s.v = coin(); s.r = s.v ? 1'b0 : coin(); s.l = coin();
      s.ld = coin(); s.cf = coin(); s.start = coin();
      q.push_back(s);
    end
    s = mk("arm beat", 1, 0, 0, 1, 1, 0, 0, 8'(j));
    s.v = 1'b1; s.r = 1'b1; s.l = (B == 1);
    q.push_back(s);
    for (int b = 1; b < B; b++) begin
      w = clean ? 0 : $urandom_range(0, 2);
      for (int k = 0; k < w; k++) begin
        s = mk("drain wait", 1, 0, 0, 0, 1, 0, 0, 8'(j));
        s.v = coin(); s.r = s.v ? 1'b0 : coin(); s.l = coin(); s.ld = coin(); s.cf = coin();
        q.push_back(s);
      end
      if (b == B - 1) begin
        for (int k = 0; k < stall; k++) begin
          s = mk("drain stall", 1, 0, 0, 0, 1, 0, 0, 8'(j));
          s.v = 1'b1; s.l = 1'b1; s.r = 1'b0;
          q.push_back(s);
        end
      end
      s = mk("drain beat", 1, 0, 0, 0, 1, 0, 0, 8'(j));
      s.v = 1'b1; s.r = 1'b1; s.l = (b == B - 1);
      q.push_back(s);
    end
    s = mk("gap", 0, 0, 0, 0, 1, 0, 0, 8'(j));
    if (!clean) begin
      s.start = coin(); s.ld = coin(); s.cf = coin(); s.v = coin(); s.l = coin(); s.r = coin();
    end
    q.push_back(s);
  endtask

  initial begin
    step_t s;
    int    nj;
    rst = 1'b1; start = 1'b0; n_jobs = '0; load_done = 1'b0; core_fin = 1'b0;
    dst_valid = 1'b0; dst_last = 1'b0; dst_ready = 1'b0;
    lastIdx = '0;

    s = mk("reset", 0, 0, 0, 0, 0, 0, 0, 8'd0); s.chk = 1'b0; s.rst = 1'b1; q.push_back(s);
    s = mk("reset state", 0, 0, 0, 0, 0, 0, 0, 8'd0); s.rst = 1'b1; q.push_back(s);
    pushIdle("idle", 2);

    // Zero-job batch: done pulse only.
    pushStart(0, 0);
    pushIdle("idle", 2);

    // Two clean jobs: load_done after 3, core_fin after 5, 4 beats.
    pushStart(2, 0);
    genJob(0, 3, 5, 4, 0, 1);
    genJob(1, 3, 5, 4, 0, 1);
    pushDone(2);

    // Single-beat stream and core_fin together with core_start.
    pushStart(1, 0);
    genJob(0, 2, 0, 1, 0, 1);
    pushDone(1);

    // Long backpressure in DRAIN must not fault.
    pushStart(1, 0);
    genJob(0, 1, 1, 4, 6000, 0);
    pushDone(1);

    // load_done on the last allowed LOAD cycle wins over the timeout.
    pushStart(1, 0);
    genJob(0, TIMEOUT - 1, 2, 2, 0, 0);
    pushDone(1);

    // load_done never arrives: FAULT exactly TIMEOUT cycles after LOAD entry.
    pushStart(2, 0);
    lastIdx = '0;
    for (int k = 0; k < TIMEOUT; k++) begin
      s = mk("load hang", 1, 1, 0, 0, 1, 0, 0, 8'd0);
      s.cf = coin(); s.l = coin(); s.start = coin();
      q.push_back(s);
    end
    for (int k = 0; k < 3; k++) q.push_back(mk("fault", 0, 0, 0, 0, 0, 0, 1, 8'd0));
    pushStart(2, 1);
    genJob(0, 2, 3, 3, 0, 0);
    genJob(1, 1, 1, 2, 0, 0);
    pushDone(2);

    // Reset during EXEC of job 1 of 3; stray start/core_fin while busy.
    pushStart(3, 0);
    genJob(0, 2, 2, 2, 0, 1);
    s = mk("load j1", 1, 1, 0, 0, 1, 0, 0, 8'd1); s.cf = 1'b1; s.start = 1'b1; q.push_back(s);
    s = mk("load j1", 1, 1, 0, 0, 1, 0, 0, 8'd1); s.ld = 1'b1; q.push_back(s);
    s = mk("exec j1", 1, 0, 1, 0, 1, 0, 0, 8'd1); s.start = 1'b1; q.push_back(s);
    s = mk("exec j1 rst", 1, 0, 0, 0, 1, 0, 0, 8'd1); s.rst = 1'b1; q.push_back(s);
    s = mk("after rst", 0, 0, 0, 0, 0, 0, 0, 8'd0); s.cf = 1'b1; q.push_back(s);
    lastIdx = '0;
    pushIdle("after rst", 3);

    // Randomized batches with stray inputs.
    for (int b = 0; b < 6; b++) begin
      nj = $urandom_range(1, 4);
      pushStart(nj, 0);
      for (int j = 0; j < nj; j++) begin
        genJob(j, $urandom_range(0, 6), $urandom_range(0, 6), $urandom_range(1, 5), 0, 0);
      end
      pushDone(nj);
      pushIdle("idle", $urandom_range(0, 2));
    end

    foreach (q[i]) begin
      @(negedge clk);
      if (q[i].chk) begin
        checkOutput(q[i].tag, {run, load_req, core_start, stream_ok, busy, done, fault, job_idx},
                    q[i].exp);
      end
      applyStimulus(q[i]);
    end
    @(negedge clk);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
